// File: rtl/vec_mem_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vec_mem_unit_pkg
// Brief    : Shared vector datapath sizes and vec_mem_unit FSM encoding.
// Revision : 1.0
// ============================================================================
package vec_mem_unit_pkg;

   localparam int c_lanes  = 16;
   localparam int c_lane_w = 16;
   localparam int c_addr_w = 16;
   localparam int c_k_w    = 4;

   localparam logic [c_k_w-1:0] c_k_last = 4'd15;

   typedef logic [2:0] state_t;

   localparam state_t c_st_idle  = 3'd0;
   localparam state_t c_st_load  = 3'd1;
   localparam state_t c_st_drain = 3'd2;
   localparam state_t c_st_store = 3'd3;
   localparam state_t c_st_done  = 3'd4;

endpackage
`default_nettype wire

// File: rtl/vec_mem_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : vec_mem_unit_if
// Brief    : Request/response and word-memory signals of the vector memory unit.
// Revision : 1.0
// ============================================================================
interface vec_mem_unit_if #(
   parameter int LANES  = vec_mem_unit_pkg::c_lanes,
   parameter int LANE_W = vec_mem_unit_pkg::c_lane_w,
   parameter int ADDR_W = vec_mem_unit_pkg::c_addr_w
) ();

   logic                    start;
   logic                    is_store;
   logic [ADDR_W-1:0]       base_addr;
   logic [LANES*LANE_W-1:0] wdata;
   logic                    busy;
   logic                    done;
   logic [LANES*LANE_W-1:0] rdata;

   logic [ADDR_W-1:0]       mem_addr;
   logic                    mem_re;
   logic                    mem_we;
   logic [LANE_W-1:0]       mem_wdata;
   logic [LANE_W-1:0]       mem_rdata;

   modport slave (
      input  start, is_store, base_addr, wdata, mem_rdata,
      output busy, done, rdata, mem_addr, mem_re, mem_we, mem_wdata
   );

   modport master (
      output start, is_store, base_addr, wdata, mem_rdata,
      input  busy, done, rdata, mem_addr, mem_re, mem_we, mem_wdata
   );

endinterface
`default_nettype wire

// File: rtl/vec_lane_sel.sv
`default_nettype none
// ============================================================================
// Module   : vec_lane_sel
// Brief    : Combinational selection of one lane from a packed vector.
// Revision : 1.0
// ============================================================================
module vec_lane_sel #(
   parameter int LANES  = 16,
   parameter int LANE_W = 16,
   parameter int IDX_W  = 4
) (
   input  logic [LANES*LANE_W-1:0] i_vec,
   input  logic [IDX_W-1:0]        i_idx,
   output logic [LANE_W-1:0]       o_word
);

   always_comb begin
      o_word = i_vec[int'(i_idx)*LANE_W +: LANE_W];
   end

endmodule
`default_nettype wire

// File: rtl/vec_mem_unit.sv
`default_nettype none
// ============================================================================
// Module   : vec_mem_unit
// Brief    : Serialises vector loads/stores into one word access per cycle.
// Revision : 1.0
// ============================================================================
module vec_mem_unit
   import vec_mem_unit_pkg::*;
#(
   parameter int LANES  = c_lanes,
   parameter int LANE_W = c_lane_w,
   parameter int ADDR_W = c_addr_w
) (
   input  logic          clk,
   input  logic          rst_n,
   vec_mem_unit_if.slave bus
);

   state_t                  r_state;
   state_t                  w_next_state;
   logic [c_k_w-1:0]        r_k;
   logic [c_k_w-1:0]        r_cap_idx;
   logic                    r_cap_valid;
   logic [ADDR_W-1:0]       r_base;
   logic [LANES*LANE_W-1:0] r_wdata;
   logic [LANES*LANE_W-1:0] r_rdata;
   logic [ADDR_W-1:0]       w_lane_addr;
   logic [LANE_W-1:0]       w_lane_word;

   // Natural ADDR_W-bit overflow gives the wrap from the top of memory to 0.
   assign w_lane_addr = r_base + ADDR_W'(r_k);

   vec_lane_sel #(
      .LANES  (LANES),
      .LANE_W (LANE_W),
      .IDX_W  (c_k_w)
   ) u_lane_sel (
      .i_vec  (r_wdata),
      .i_idx  (r_k),
      .o_word (w_lane_word)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_st_idle:  if (bus.start) w_next_state = bus.is_store ? c_st_store : c_st_load;
         c_st_load:  if (r_k == c_k_last) w_next_state = c_st_drain;
         c_st_store: if (r_k == c_k_last) w_next_state = c_st_done;
         c_st_drain: w_next_state = c_st_done;
         c_st_done:  w_next_state = c_st_idle;
         default:    w_next_state = c_st_idle;
      endcase
   end

   always_comb begin
      bus.busy      = 1'b0;
      bus.done      = 1'b0;
      bus.mem_re    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      case (r_state)
         c_st_load: begin
            bus.busy     = 1'b1;
            bus.mem_re   = 1'b1;
            bus.mem_addr = w_lane_addr;
         end
         c_st_store: begin
            bus.busy      = 1'b1;
            bus.mem_we    = 1'b1;
            bus.mem_addr  = w_lane_addr;
            bus.mem_wdata = w_lane_word;
         end
         c_st_drain: bus.busy = 1'b1;
         c_st_done: begin
            bus.busy = 1'b1;
            bus.done = 1'b1;
         end
         default: ;
      endcase
   end

   // Read data lags the strobe by one cycle, so the lane index rides along.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_k         <= '0;
         r_cap_idx   <= '0;
         r_cap_valid <= 1'b0;
         r_base      <= '0;
         r_wdata     <= '0;
         r_rdata     <= '0;
      end else begin
         r_cap_valid <= (r_state == c_st_load);
         r_cap_idx   <= r_k;
         if (r_cap_valid) begin
            r_rdata[int'(r_cap_idx)*LANE_W +: LANE_W] <= bus.mem_rdata;
         end
         case (r_state)
            c_st_idle: begin
               if (bus.start) begin
                  r_base  <= bus.base_addr;
                  r_wdata <= bus.wdata;
                  r_k     <= '0;
               end
            end
            c_st_load, c_st_store: r_k <= r_k + 1'b1;
            default: ;
         endcase
      end
   end

   assign bus.rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_vec_mem_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_vec_mem_unit
// Brief    : Self-checking bench for vec_mem_unit against a word-memory model.
// Revision : 1.0
// ============================================================================
module tb_vec_mem_unit;

   localparam int LANES  = 16;
   localparam int LANE_W = 16;
   localparam int ADDR_W = 16;
   localparam int VW     = LANES * LANE_W;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   vec_mem_unit_if #(.LANES(LANES), .LANE_W(LANE_W), .ADDR_W(ADDR_W)) bus ();

   vec_mem_unit #(
      .LANES  (LANES),
      .LANE_W (LANE_W),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;

   // Data memory: unwritten words read back a fixed address-derived pattern.
   logic [15:0] mem     [0:65535];
   bit          written [0:65535];
   logic [15:0] ref_mem [0:65535];
   logic [VW-1:0] model_rdata;

   function automatic logic [15:0] init_val(input logic [15:0] a);
      if (a >= 16'h0200 && a <= 16'h020F) return 16'hA000 + (a - 16'h0200);
      return (a * 16'd7) ^ 16'h5A5A;
   endfunction

   always @(posedge clk) begin
      if (bus.mem_we) begin
         mem[bus.mem_addr]     <= bus.mem_wdata;
         written[bus.mem_addr] <= 1'b1;
      end
      if (bus.mem_re) begin
         bus.mem_rdata <= written[bus.mem_addr] ? mem[bus.mem_addr] : init_val(bus.mem_addr);
      end
   end

   // Per-cycle trace of one operation; index 1 is the cycle after acceptance.
   bit          tr_re   [0:31];
   bit          tr_we   [0:31];
   bit          tr_done [0:31];
   bit          tr_busy [0:31];
   logic [15:0] tr_addr [0:31];
   logic [15:0] tr_wd   [0:31];
   logic [VW-1:0] tr_rd [0:31];
   int tr_n;
   int tr_wait;

   task automatic run_op(input bit st, input logic [15:0] base, input logic [VW-1:0] wv,
                         input int extra);
      int guard;
      @(negedge clk);
      guard   = 0;
      tr_wait = 0;
      while (bus.busy === 1'b1 && guard < 40) begin
         @(negedge clk);
         guard++;
         tr_wait++;
      end
      bus.start     = 1'b1;
      bus.is_store  = st;
      bus.base_addr = base;
      bus.wdata     = wv;
      @(posedge clk);
      #1;
      tr_n = 0;
      for (int c = 1; c < 31; c++) begin
         bus.start = (c == extra);
         if (c == extra) begin
            bus.is_store  = ~st;
            bus.base_addr = ~base;
            bus.wdata     = ~wv;
         end
         tr_re[c]   = bus.mem_re;
         tr_we[c]   = bus.mem_we;
         tr_done[c] = bus.done;
         tr_busy[c] = bus.busy;
         tr_addr[c] = bus.mem_addr;
         tr_wd[c]   = bus.mem_wdata;
         tr_rd[c]   = bus.rdata;
         tr_n       = c;
         if (bus.done === 1'b1) break;
         @(posedge clk);
         #1;
      end
      bus.start = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({bus.busy, bus.done, bus.mem_re, bus.mem_we} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_ctrl got=%b want=0000", {bus.busy, bus.done, bus.mem_re, bus.mem_we});
      end
      checks++;
      if ({bus.mem_addr, bus.mem_wdata} !== 32'h0) begin
         failures++;
         $display("FAIL reset_bus got=%h want=00000000", {bus.mem_addr, bus.mem_wdata});
      end
      checks++;
      if (bus.rdata !== '0) begin
         failures++;
         $display("FAIL reset_rdata got=%h want=0", bus.rdata);
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_rdata = '0;
   endtask

   task automatic test_store;
      logic [15:0] base, a;
      logic [VW-1:0] wv;
      logic [35:0] act_v, exp_v;
      int ln;
      for (int n = 0; n < 4; n++) begin
         base = (n == 0) ? 16'h0100 : 16'($urandom);
         for (int i = 0; i < 16; i++) wv[i*16 +: 16] = (n == 0) ? 16'h1000 + 16'(i) : 16'($urandom);
         run_op(1'b1, base, wv, 0);
         checks++;
         if (tr_n !== 17) begin
            failures++;
            $display("FAIL store_done_cycle op=%0d got=%0d want=17", n, tr_n);
         end
         for (int c = 1; c <= tr_n; c++) begin
            ln    = (c <= 16) ? c - 1 : 0;
            exp_v = {1'b0, (c <= 16), (c <= 16) ? base + 16'(ln) : 16'h0,
                     (c <= 16) ? wv[ln*16 +: 16] : 16'h0, (c == 17), (c <= 17)};
            act_v = {tr_re[c], tr_we[c], tr_addr[c], tr_wd[c], tr_done[c], tr_busy[c]};
            checks++;
            if (act_v !== exp_v) begin
               failures++;
               $display("FAIL store_cycle op=%0d c=%0d got=%h want=%h", n, c, act_v, exp_v);
            end
         end
         checks++;
         if (tr_rd[tr_n] !== model_rdata) begin
            failures++;
            $display("FAIL store_rdata_held op=%0d got=%h want=%h", n, tr_rd[tr_n], model_rdata);
         end
         for (int i = 0; i < 16; i++) begin
            a = base + 16'(i);
            ref_mem[a] = wv[i*16 +: 16];
         end
      end
   endtask

   task automatic test_load;
      logic [15:0] base, a;
      logic [VW-1:0] exp_rd;
      logic [35:0] act_v, exp_v;
      for (int n = 0; n < 4; n++) begin
         base = (n == 0) ? 16'h0200 : (n == 1) ? 16'h0100 : 16'($urandom);
         for (int i = 0; i < 16; i++) begin
            a = base + 16'(i);
            exp_rd[i*16 +: 16] = ref_mem[a];
         end
         run_op(1'b0, base, VW'($urandom), 0);
         checks++;
         if (tr_n !== 18) begin
            failures++;
            $display("FAIL load_done_cycle op=%0d got=%0d want=18", n, tr_n);
         end
         for (int c = 1; c <= tr_n; c++) begin
            exp_v = {(c <= 16), 1'b0, (c <= 16) ? base + 16'(c - 1) : 16'h0, 16'h0,
                     (c == 18), (c <= 18)};
            act_v = {tr_re[c], tr_we[c], tr_addr[c], tr_wd[c], tr_done[c], tr_busy[c]};
            checks++;
            if (act_v !== exp_v) begin
               failures++;
               $display("FAIL load_cycle op=%0d c=%0d got=%h want=%h", n, c, act_v, exp_v);
            end
         end
         checks++;
         if (tr_rd[tr_n] !== exp_rd) begin
            failures++;
            $display("FAIL load_rdata op=%0d got=%h want=%h", n, tr_rd[tr_n], exp_rd);
         end
         model_rdata = exp_rd;
      end
   endtask

   task automatic test_wrap;
      logic [15:0] base, a;
      logic [VW-1:0] wv, exp_rd;
      logic [35:0] act_v, exp_v;
      bit st;
      int dc, ln;
      for (int n = 0; n < 3; n++) begin
         st   = (n == 1);
         base = (n == 1) ? 16'hFFFC : 16'hFFF8;
         for (int i = 0; i < 16; i++) wv[i*16 +: 16] = 16'($urandom);
         for (int i = 0; i < 16; i++) begin
            a = base + 16'(i);
            exp_rd[i*16 +: 16] = ref_mem[a];
         end
         dc = st ? 17 : 18;
         run_op(st, base, wv, 0);
         checks++;
         if (tr_n !== dc) begin
            failures++;
            $display("FAIL wrap_done_cycle op=%0d got=%0d want=%0d", n, tr_n, dc);
         end
         for (int c = 1; c <= tr_n; c++) begin
            ln    = (c <= 16) ? c - 1 : 0;
            exp_v = {!st && c <= 16, st && c <= 16, (c <= 16) ? base + 16'(ln) : 16'h0,
                     (st && c <= 16) ? wv[ln*16 +: 16] : 16'h0, (c == dc), (c <= dc)};
            act_v = {tr_re[c], tr_we[c], tr_addr[c], tr_wd[c], tr_done[c], tr_busy[c]};
            checks++;
            if (act_v !== exp_v) begin
               failures++;
               $display("FAIL wrap_cycle op=%0d c=%0d got=%h want=%h", n, c, act_v, exp_v);
            end
         end
         if (st) begin
            for (int i = 0; i < 16; i++) begin
               a = base + 16'(i);
               ref_mem[a] = wv[i*16 +: 16];
            end
         end else begin
            model_rdata = exp_rd;
         end
         checks++;
         if (tr_rd[tr_n] !== model_rdata) begin
            failures++;
            $display("FAIL wrap_rdata op=%0d got=%h want=%h", n, tr_rd[tr_n], model_rdata);
         end
      end
   endtask

   task automatic test_start_while_busy;
      logic [15:0] base, a;
      logic [VW-1:0] wv;
      int writes, dones, stray;
      base = 16'($urandom);
      for (int i = 0; i < 16; i++) wv[i*16 +: 16] = 16'($urandom);
      run_op(1'b1, base, wv, 5);
      writes = 0;
      dones  = 0;
      for (int c = 1; c <= tr_n; c++) begin
         if (tr_we[c]) begin
            writes++;
            checks++;
            if (tr_addr[c] !== base + 16'(c - 1) || tr_wd[c] !== wv[(c-1)*16 +: 16]) begin
               failures++;
               $display("FAIL busy_write c=%0d got=%h/%h want=%h/%h", c, tr_addr[c], tr_wd[c],
                        base + 16'(c - 1), wv[(c-1)*16 +: 16]);
            end
         end
         if (tr_done[c]) dones++;
      end
      stray = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         #1;
         if (bus.mem_we || bus.mem_re || bus.done || bus.busy) stray++;
      end
      checks++;
      if (writes !== 16 || dones !== 1 || stray !== 0) begin
         failures++;
         $display("FAIL busy_ignore got writes=%0d dones=%0d stray=%0d want 16/1/0",
                  writes, dones, stray);
      end
      for (int i = 0; i < 16; i++) begin
         a = base + 16'(i);
         ref_mem[a] = wv[i*16 +: 16];
      end
   endtask

   task automatic test_reset_mid_load;
      logic [15:0] base, a;
      logic [VW-1:0] exp_rd;
      int stray;
      @(negedge clk);
      base          = 16'($urandom);
      bus.start     = 1'b1;
      bus.is_store  = 1'b0;
      bus.base_addr = base;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      for (int c = 1; c < 8; c++) begin
         @(posedge clk);
         #1;
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.busy, bus.done, bus.mem_re, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== 36'h0) begin
         failures++;
         $display("FAIL midreset_outputs got=%h want=0",
                  {bus.busy, bus.done, bus.mem_re, bus.mem_we, bus.mem_addr, bus.mem_wdata});
      end
      checks++;
      if (bus.rdata !== '0) begin
         failures++;
         $display("FAIL midreset_rdata got=%h want=0", bus.rdata);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_rdata = '0;
      stray = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         #1;
         if (bus.mem_re || bus.mem_we || bus.done || bus.busy) stray++;
      end
      checks++;
      if (stray !== 0) begin
         failures++;
         $display("FAIL midreset_abort got=%0d active cycles want=0", stray);
      end
      base = 16'($urandom);
      for (int i = 0; i < 16; i++) begin
         a = base + 16'(i);
         exp_rd[i*16 +: 16] = ref_mem[a];
      end
      run_op(1'b0, base, '0, 0);
      checks++;
      if (tr_n !== 18 || tr_rd[tr_n] !== exp_rd) begin
         failures++;
         $display("FAIL midreset_fresh_load got n=%0d rd=%h want n=18 rd=%h", tr_n, tr_rd[tr_n], exp_rd);
      end
      model_rdata = exp_rd;
   endtask

   task automatic test_back_to_back;
      logic [15:0] base, a;
      logic [VW-1:0] prev_rd, exp_rd, exp3, wv;
      for (int n = 0; n < 2; n++) begin
         prev_rd = model_rdata;
         base    = 16'($urandom);
         for (int i = 0; i < 16; i++) begin
            a = base + 16'(i);
            exp_rd[i*16 +: 16] = ref_mem[a];
         end
         run_op(1'b0, base, '0, 0);
         if (n == 1) begin
            checks++;
            if (tr_wait !== 1) begin
               failures++;
               $display("FAIL b2b_accept_cycle got wait=%0d want=1", tr_wait);
            end
         end
         exp3 = {prev_rd[VW-1:16], exp_rd[15:0]};
         checks++;
         if (tr_rd[1] !== prev_rd || tr_rd[2] !== prev_rd || tr_rd[3] !== exp3) begin
            failures++;
            $display("FAIL b2b_rdata_hold op=%0d got=%h want=%h", n, tr_rd[3], exp3);
         end
         checks++;
         if (tr_n !== 18 || tr_rd[tr_n] !== exp_rd) begin
            failures++;
            $display("FAIL b2b_load op=%0d got n=%0d rd=%h want n=18 rd=%h", n, tr_n, tr_rd[tr_n], exp_rd);
         end
         model_rdata = exp_rd;
      end
      base = 16'($urandom);
      for (int i = 0; i < 16; i++) wv[i*16 +: 16] = 16'($urandom);
      run_op(1'b1, base, wv, 0);
      checks++;
      if (tr_wait !== 1 || tr_n !== 17 || tr_rd[tr_n] !== model_rdata) begin
         failures++;
         $display("FAIL b2b_store got wait=%0d n=%0d rd=%h want 1/17/%h",
                  tr_wait, tr_n, tr_rd[tr_n], model_rdata);
      end
      for (int i = 0; i < 16; i++) begin
         a = base + 16'(i);
         ref_mem[a] = wv[i*16 +: 16];
      end
   endtask

   initial begin
      bus.start     = 1'b0;
      bus.is_store  = 1'b0;
      bus.base_addr = '0;
      bus.wdata     = '0;
      model_rdata   = '0;
      for (int a = 0; a < 65536; a++) ref_mem[a] = init_val(16'(a));
      test_reset;
      test_store;
      test_load;
      test_wrap;
      test_start_while_busy;
      test_reset_mid_load;
      test_back_to_back;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
